// File: rtl/sw_debounce.sv
// Switch input conditioner: two-flop synchroniser followed by a whole-vector debounce FSM.
// Publishes the committed vector plus a one-cycle change strobe with rise/fall masks.
module sw_debounce #(
  parameter int unsigned WIDTH           = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw,
  output logic             changed,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StCount,
    StCommit
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sw_meta_q, sw_sync_q;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sw_q, sw_d;
  logic             changed_q, changed_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      sw_meta_q <= sw_in;
      sw_sync_q <= sw_meta_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    sw_d      = sw_q;
    changed_d = 1'b0;
    rise_d    = '0;
    fall_d    = '0;
    unique case (state_q)
      StIdle: begin
        if (sw_sync_q != sw_q) begin
          cand_d  = sw_sync_q;
          cnt_d   = '0;
          state_d = StCount;
        end
      end
      StCount: begin
        if (sw_sync_q == sw_q) begin
          // Input bounced back to the committed value: abandon the window.
          cnt_d   = '0;
          state_d = StIdle;
        end else if (sw_sync_q != cand_q) begin
          cand_d = sw_sync_q;
          cnt_d  = '0;
        end else if (cnt_q == CntLast) begin
          state_d = StCommit;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StCommit: begin
        sw_d      = cand_q;
        changed_d = 1'b1;
        rise_d    = cand_q & ~sw_q;
        fall_d    = ~cand_q & sw_q;
        cnt_d     = '0;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cand_q    <= '0;
      cnt_q     <= '0;
      sw_q      <= '0;
      changed_q <= 1'b0;
      rise_q    <= '0;
      fall_q    <= '0;
    end else begin
      state_q   <= state_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      sw_q      <= sw_d;
      changed_q <= changed_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
    end
  end

  assign sw      = sw_q;
  assign changed = changed_q;
  assign rise    = rise_q;
  assign fall    = fall_q;

endmodule

// File: tb/tb_sw_debounce.sv
// Scoreboard bench for sw_debounce with DEBOUNCE_CYCLES=4: stimulus queues expected commits,
// a monitor pops and checks them whenever changed is seen.
module tb_sw_debounce;

  localparam int unsigned W  = 16;
  localparam int unsigned DC = 4;

  typedef struct {
    logic [W-1:0] sw;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    int           edge_no;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] sw_in = '0;
  logic [W-1:0] sw;
  logic         changed;
  logic [W-1:0] rise;
  logic [W-1:0] fall;

  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  exp_t sb_q[$];

  sw_debounce #(
    .WIDTH          (W),
    .DEBOUNCE_CYCLES(DC),
    .CNT_W          (24)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .sw_in  (sw_in),
    .sw     (sw),
    .changed(changed),
    .rise   (rise),
    .fall   (fall)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Expect a commit DC+4 edges after the change applied at the current negedge.
  task automatic expect_commit(input logic [W-1:0] s, input logic [W-1:0] r,
                               input logic [W-1:0] f);
    exp_t e;
    e.sw = s; e.rise = r; e.fall = f; e.edge_no = cyc + DC + 4;
    sb_q.push_back(e);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (changed) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse: changed=1 sw=%h, expected no pulse (cycle %0d)",
                   sw, cyc);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("commit_sw", sw, e.sw);
          check("commit_rise", rise, e.rise);
          check("commit_fall", fall, e.fall);
          checks++;
          if (cyc != e.edge_no) begin
            errors++;
            $display("FAIL commit_edge: got edge %0d, expected edge %0d", cyc, e.edge_no);
          end
        end
      end else begin
        check("idle_rise_zero", rise, '0);
        check("idle_fall_zero", fall, '0);
      end
    end
  end

  initial begin
    // 1: reset with all switches high
    sw_in = 16'hFFFF;
    rst   = 1'b1;
    wait_cycles(3);
    check("rst_sw", sw, 16'h0000);
    check("rst_changed", {15'd0, changed}, 16'h0000);
    rst = 1'b0;
    expect_commit(16'hFFFF, 16'hFFFF, 16'h0000);
    wait_cycles(14);
    check("t1_sw", sw, 16'hFFFF);

    // 2: clean step via 0000
    sw_in = 16'h0000;
    expect_commit(16'h0000, 16'h0000, 16'hFFFF);
    wait_cycles(14);
    sw_in = 16'h00A5;
    expect_commit(16'h00A5, 16'h00A5, 16'h0000);
    wait_cycles(20);
    check("t2_sw", sw, 16'h00A5);

    // 3: bounce on bit0, ends at 00A5
    for (int i = 0; i < 10; i++) begin
      sw_in = (i % 2 == 0) ? 16'h00A4 : 16'h00A5;
      wait_cycles(1);
    end
    wait_cycles(20);
    check("t3_sw", sw, 16'h00A5);

    // 4: restart on new pattern
    sw_in = 16'h0000;
    expect_commit(16'h0000, 16'h0000, 16'h00A5);
    wait_cycles(14);
    sw_in = 16'h0001;
    wait_cycles(2);
    sw_in = 16'h0003;
    expect_commit(16'h0003, 16'h0003, 16'h0000);
    wait_cycles(16);
    check("t4_sw", sw, 16'h0003);

    // 5: mixed edges
    sw_in = 16'h00F0;
    expect_commit(16'h00F0, 16'h00F0, 16'h0003);
    wait_cycles(14);
    sw_in = 16'h000F;
    expect_commit(16'h000F, 16'h000F, 16'h00F0);
    wait_cycles(14);
    check("t5_sw", sw, 16'h000F);

    // 6: reset mid-count (cnt reaches 2 after 5 edges)
    sw_in = 16'h1234;
    wait_cycles(5);
    rst = 1'b1;
    #1;
    check("t6_rst_sw", sw, 16'h0000);
    check("t6_rst_changed", {15'd0, changed}, 16'h0000);
    check("t6_rst_rise", rise, 16'h0000);
    check("t6_rst_fall", fall, 16'h0000);
    wait_cycles(3);
    rst = 1'b0;
    expect_commit(16'h1234, 16'h1234, 16'h0000);
    wait_cycles(16);
    check("t6_sw", sw, 16'h1234);

    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL pending_commits: %0d expected commits never seen, expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
